updown_counter_param: RTL

Parametrised up/down counter, successor to the fixed 8-bit up/down counter.
- Width and upper bound are generic.
- Adds count enable, synchronous parallel load, and a per-cycle choice of wrap or saturate at the bounds.
- Adds boundary decodes, a one-cycle wrap/saturate event pulse, and sticky overflow/underflow flags.
- Used as the general-purpose event/position counter in the datapath, e.g. modulo-N sequencers and bounded credit counters.

---
 rtl/updown_counter_pkg.sv | 22 ++
 rtl/updown_next_val.sv | 50 +++++
 rtl/updown_counter_param.sv | 105 ++++++++++
 3 files changed

// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared types and constants for the parametrised up/down counter
package updown_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  // Largest value representable in `width` bits, used as the default upper bound.
  function automatic logic [31:0] default_limit(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/updown_next_val.sv
// rtl/updown_next_val.sv - combinational one-step successor with wrap/saturate at 0 and limit
module updown_next_val
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur_val,
  input  dir_e             dir,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] next_val,
  output logic             hit,
  output dir_e             hit_dir
);

  logic [WIDTH:0] cur_ext;
  logic [WIDTH:0] lim_ext;
  logic [WIDTH:0] nxt_ext;
  logic           unused_carry;

  // One extra bit keeps the +1 at the top of the range from aliasing to zero.
  always_comb begin
    cur_ext = {1'b0, cur_val};
    lim_ext = {1'b0, limit};
    nxt_ext = cur_ext;
    hit     = 1'b0;
    hit_dir = DIR_UP;
    if (dir == DIR_UP) begin
      if (cur_ext >= lim_ext) begin
        hit     = 1'b1;
        hit_dir = DIR_UP;
        nxt_ext = (mode == MODE_SAT) ? lim_ext : '0;
      end else begin
        nxt_ext = cur_ext + 1'b1;
      end
    end else begin
      if (cur_ext == '0) begin
        hit     = 1'b1;
        hit_dir = DIR_DOWN;
        nxt_ext = (mode == MODE_SAT) ? '0 : lim_ext;
      end else begin
        nxt_ext = cur_ext - 1'b1;
      end
    end
  end

  assign next_val     = nxt_ext[WIDTH-1:0];
  assign unused_carry = nxt_ext[WIDTH];

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - bounded up/down counter with load, wrap/saturate, event and sticky flags
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] LIMIT     = WIDTH'(default_limit(WIDTH)),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_min,
  output logic             evt,
  output logic             ovf_sticky,
  output logic             unf_sticky
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be 2..32");
  end
  if (LIMIT == '0) begin : g_bad_limit
    $error("updown_counter_param: LIMIT must be at least 1");
  end
  if (RESET_VAL > LIMIT) begin : g_bad_reset_val
    $error("updown_counter_param: RESET_VAL must not exceed LIMIT");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  dir_e             dir;
  mode_e            mode;
  logic [WIDTH-1:0] step_val;
  logic             step_hit;
  dir_e             step_hit_dir;
  logic [WIDTH-1:0] load_clamped;

  assign dir          = up_down  ? DIR_UP   : DIR_DOWN;
  assign mode         = sat_mode ? MODE_SAT : MODE_WRAP;
  assign load_clamped = (load_val > LIMIT) ? LIMIT : load_val;

  updown_next_val #(
    .WIDTH(WIDTH)
  ) u_next (
    .cur_val  (out_q),
    .dir      (dir),
    .mode     (mode),
    .limit    (LIMIT),
    .next_val (step_val),
    .hit      (step_hit),
    .hit_dir  (step_hit_dir)
  );

  // Load beats stepping; a boundary step raises evt and sets its flag, which wins over clr_flags.
  always_comb begin
    out_d = out_q;
    evt_d = 1'b0;
    ovf_d = ovf_q & ~clr_flags;
    unf_d = unf_q & ~clr_flags;
    if (load) begin
      out_d = load_clamped;
    end else if (en) begin
      out_d = step_val;
      evt_d = step_hit;
      if (step_hit && step_hit_dir == DIR_UP) begin
        ovf_d = 1'b1;
      end
      if (step_hit && step_hit_dir == DIR_DOWN) begin
        unf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VAL;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      evt_q <= evt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign out        = out_q;
  assign evt        = evt_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
  assign at_max     = (out_q == LIMIT);
  assign at_min     = (out_q == '0);

endmodule
